postfft_seq_ctrl: RTL and testbench

Parametrised sequencer for the post-FFT channel-estimation chain. After the cell ID is known it starts DMRS generation, steps through NUM_SYM DMRS-bearing symbols (one MMSE pass each), then holds channel averaging until it completes. It adds abort, busy/done status, overrun flagging and an optional watchdog timeout, and sits between the cell-search result and the DMRS generator, MMSE and averaging engines.

---
 rtl/postfft_pkg.sv | 15 +
 rtl/postfft_seq_ctrl_wdog.sv | 30 +++
 rtl/postfft_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_postfft_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/postfft_pkg.sv
// Shared definitions for the post-FFT channel-estimation chain:
// sequencer state encoding and default symbol-count parameters.
package postfft_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DMRS_GEN = 2'd1,
        PROCESS  = 2'd2,
        AVG      = 2'd3
    } state_t;

    localparam int NUM_SYM_DEF = 4;
    localparam int SYM_W_DEF   = 2;

endpackage

// File: rtl/postfft_seq_ctrl_wdog.sv
// Watchdog counter for the post-FFT sequencer: clears on clr, counts
// while en, and flags expire when the count reaches TIMEOUT_CYC-1.
module postfft_wdog #(
    parameter int TO_W        = 12,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/postfft_seq_ctrl.sv
// Post-FFT sequencer: DMRS gen -> NUM_SYM MMSE passes -> averaging.
// Define POSTFFT_SEQ_WDOG_EN to build the watchdog timeout.
module postfft_seq_ctrl
    import postfft_pkg::*;
#(
    parameter int NUM_SYM     = NUM_SYM_DEF,
    parameter int SYM_W       = SYM_W_DEF,
    parameter int TO_W        = 12,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ncellid_ready_pulse,
    input  logic             abort,
    input  logic             dmrs_gen_done,
    input  logic             mmse_done,
    input  logic             avg_done,
    output logic             dmrs_gen_start,
    output logic [SYM_W-1:0] symbol_num,
    output logic             symbol_num_vld,
    output logic             ch_avg_start,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(NUM_SYM - 1);

    state_t           state, state_n;
    logic [SYM_W-1:0] sym_n;
    logic             start_n, vld_n, avg_n, done_n, ovr_n, to_n;
    logic             done_acc;
    logic             wdog_exp;

    always_comb begin
        state_n  = state;
        sym_n    = symbol_num;
        start_n  = 1'b0;
        vld_n    = 1'b0;
        avg_n    = ch_avg_start;
        done_n   = 1'b0;
        ovr_n    = 1'b0;
        to_n     = 1'b0;
        done_acc = 1'b0;
        if (abort || wdog_exp) begin
            // Abort wins over timeout; both leave without a done pulse.
            state_n = IDLE;
            sym_n   = '0;
            avg_n   = 1'b0;
            to_n    = !abort;
        end else begin
            unique case (state)
                IDLE: begin
                    sym_n = '0;
                    if (ncellid_ready_pulse) begin
                        state_n = DMRS_GEN;
                        start_n = 1'b1;
                    end
                end
                DMRS_GEN: begin
                    ovr_n = ncellid_ready_pulse;
                    if (dmrs_gen_done) begin
                        state_n  = PROCESS;
                        sym_n    = '0;
                        vld_n    = 1'b1;
                        done_acc = 1'b1;
                    end
                end
                PROCESS: begin
                    ovr_n = ncellid_ready_pulse;
                    if (mmse_done) begin
                        done_acc = 1'b1;
                        if (symbol_num == LAST_SYM) begin
                            state_n = AVG;
                            sym_n   = '0;
                            avg_n   = 1'b1;
                        end else begin
                            sym_n = symbol_num + 1'b1;
                            vld_n = 1'b1;
                        end
                    end
                end
                AVG: begin
                    ovr_n = ncellid_ready_pulse;
                    if (avg_done) begin
                        state_n  = IDLE;
                        avg_n    = 1'b0;
                        done_n   = 1'b1;
                        done_acc = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            symbol_num     <= '0;
            dmrs_gen_start <= 1'b0;
            symbol_num_vld <= 1'b0;
            ch_avg_start   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_n;
            symbol_num     <= sym_n;
            dmrs_gen_start <= start_n;
            symbol_num_vld <= vld_n;
            ch_avg_start   <= avg_n;
            busy           <= (state_n != IDLE);
            done           <= done_n;
            overrun        <= ovr_n;
        end
    end

`ifdef POSTFFT_SEQ_WDOG_EN
    logic wdog_clr;

    assign wdog_clr = ((state_n != state) && (state_n != IDLE)) || done_acc;

    postfft_wdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wdog_clr),
        .en     (state != IDLE),
        .expire (wdog_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= to_n;
        end
    end
`else
    logic unused_wdog;

    assign wdog_exp    = 1'b0;
    assign timeout     = 1'b0;
    assign unused_wdog = ^{to_n, done_acc, TO_W, TIMEOUT_CYC};
`endif

endmodule

// File: tb/tb_postfft_seq_ctrl.sv
// Directed bench for postfft_seq_ctrl (NUM_SYM=4 main DUT, NUM_SYM=1
// side DUT); define POSTFFT_SEQ_WDOG_EN for the watchdog variant.
module tb_postfft_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dgd = 1'b0;
    logic       md = 1'b0;
    logic       ad = 1'b0;

    logic       dstart, vld, avg, busy, done, ovr, tout;
    logic [1:0] sym;
    logic       dstart1, vld1, avg1, busy1, done1, ovr1, tout1;
    logic [1:0] sym1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    postfft_seq_ctrl #(
        .NUM_SYM     (4),
        .SYM_W       (2),
        .TO_W        (12),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ncellid_ready_pulse (start),
        .abort               (abort),
        .dmrs_gen_done       (dgd),
        .mmse_done           (md),
        .avg_done            (ad),
        .dmrs_gen_start      (dstart),
        .symbol_num          (sym),
        .symbol_num_vld      (vld),
        .ch_avg_start        (avg),
        .busy                (busy),
        .done                (done),
        .overrun             (ovr),
        .timeout             (tout)
    );

    postfft_seq_ctrl #(
        .NUM_SYM     (1),
        .SYM_W       (2),
        .TO_W        (12),
        .TIMEOUT_CYC (4000)
    ) dut1 (
        .clk                 (clk),
        .rst                 (rst),
        .ncellid_ready_pulse (start),
        .abort               (abort),
        .dmrs_gen_done       (dgd),
        .mmse_done           (md),
        .avg_done            (ad),
        .dmrs_gen_start      (dstart1),
        .symbol_num          (sym1),
        .symbol_num_vld      (vld1),
        .ch_avg_start        (avg1),
        .busy                (busy1),
        .done                (done1),
        .overrun             (ovr1),
        .timeout             (tout1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // {start, vld, sym[1:0], avg, busy, done, overrun, timeout}
    function automatic logic [8:0] outs();
        return {dstart, vld, sym, avg, busy, done, ovr, tout};
    endfunction

    function automatic logic [2:0] outs1();
        return {avg1, busy1, done1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("reset", outs(), 9'b0);
        chk("reset1", {dstart1, vld1, sym1, ovr1, tout1}, 6'b0);
        rst = 1'b1;
        tick();
        chk("idle", outs(), 9'b0);

        start = 1'b1; tick(); start = 1'b0;
        chk("start", outs(), 9'b1_0_00_0_1_000);
        tick();
        chk("start_1cyc", outs(), 9'b0_0_00_0_1_000);

        md = 1'b1; tick(); md = 1'b0;
        chk("stray_mmse", outs(), 9'b0_0_00_0_1_000);
        ad = 1'b1; tick(); ad = 1'b0;
        chk("stray_avg_dg", outs(), 9'b0_0_00_0_1_000);

        dgd = 1'b1; tick(); dgd = 1'b0;
        chk("vld0", outs(), 9'b0_1_00_0_1_000);
        tick();
        chk("vld0_drop", outs(), 9'b0_0_00_0_1_000);
        ad = 1'b1; tick(); ad = 1'b0;
        chk("stray_avg_pr", outs(), 9'b0_0_00_0_1_000);

        for (int i = 1; i < 4; i++) begin
            repeat (9) tick();
            md = 1'b1; tick(); md = 1'b0;
            chk($sformatf("vld%0d", i), outs(),
                {1'b0, 1'b1, 2'(i), 1'b0, 1'b1, 3'b000});
            if (i == 1)
                chk("n1_avg", outs1(), 3'b110);
            tick();
            chk($sformatf("hold%0d", i), outs(),
                {1'b0, 1'b0, 2'(i), 1'b0, 1'b1, 3'b000});
            if (i == 2) begin
                start = 1'b1; tick(); start = 1'b0;
                chk("overrun", outs(), 9'b0_0_10_0_1_010);
                tick();
                chk("overrun_1cyc", outs(), 9'b0_0_10_0_1_000);
            end
        end

        repeat (9) tick();
        md = 1'b1; tick(); md = 1'b0;
        chk("avg_rise", outs(), 9'b0_0_00_1_1_000);
        repeat (3) tick();
        chk("avg_hold", outs(), 9'b0_0_00_1_1_000);

        ad = 1'b1; start = 1'b1; tick(); ad = 1'b0; start = 1'b0;
        chk("done_ovr", outs(), 9'b0_0_00_0_0_110);
        chk("n1_done", outs1(), 3'b001);

        start = 1'b1; tick(); start = 1'b0;
        chk("b2b_start", outs(), 9'b1_0_00_0_1_000);
        dgd = 1'b1; tick(); dgd = 1'b0;
        repeat (4) begin
            md = 1'b1; tick(); md = 1'b0;
        end
        chk("avg2", outs(), 9'b0_0_00_1_1_000);
        abort = 1'b1; ad = 1'b1; tick(); abort = 1'b0; ad = 1'b0;
        chk("abort", outs(), 9'b0);
        chk("abort1", outs1(), 3'b000);
        tick();
        chk("abort_nodone", outs(), 9'b0);

        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_idle", outs(), 9'b0);

        start = 1'b1; tick(); start = 1'b0;
        dgd = 1'b1; tick(); dgd = 1'b0;
        md = 1'b1; tick();
        tick(); md = 1'b0;
        chk("sym2", outs(), 9'b0_1_10_0_1_000);
        rst = 1'b0;
        #1;
        chk("rst_async", outs(), 9'b0);
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        dgd = 1'b1; tick(); dgd = 1'b0;
        chk("restart", outs(), 9'b0_1_00_0_1_000);
        abort = 1'b1; tick(); abort = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
`ifdef POSTFFT_SEQ_WDOG_EN
        repeat (15) tick();
        chk("wd_pre", outs(), 9'b0_0_00_0_1_000);
        tick();
        chk("wd_timeout", outs(), 9'b0_0_00_0_0_001);
        tick();
        chk("wd_idle", outs(), 9'b0);
`else
        repeat (100) tick();
        chk("no_wd", outs(), 9'b0_0_00_0_1_000);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("no_wd_abort", outs(), 9'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
